mips_prog_loader: RTL

Program loader for the MIPS32 pipeline's 1024 x 32 memory. Receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction/data words and writes them to consecutive memory addresses. It verifies an XOR checksum before releasing the processor with `cpu_run`, so it acts as the writer that fills the memory the pipeline fetches from.

---
 rtl/mips_prog_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mips_prog_loader.sv
// Program loader for the MIPS32 pipeline's instruction/data memory.
// Accepts a framed byte stream (sync 0xA5, start address, word count, big-endian
// data words, XOR checksum), writes each assembled word to consecutive addresses
// and releases the processor via cpu_run only after the checksum matches.
// Optional feature: define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC
// cycles without an accepted byte.
module mips_prog_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StCntHi,
        StCntLo,
        StData,
        StChk,
        StRun
    } state_e;

    localparam logic [7:0] SyncByte = 8'hA5;

    state_e            state_q, state_d;
    logic [7:0]        hi_q, hi_d;        // high byte of the 16-bit header field in flight
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;      // first three bytes of the word being assembled
    logic [7:0]        acc_q, acc_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       hdr_word;
    logic              timeout_hit;

    assign in_ready  = 1'b1;
    assign busy      = (state_q != StIdle) && (state_q != StRun);
    assign cpu_run   = (state_q == StRun);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] to_q, to_d;

    // Inter-byte idle counter: runs only mid-frame, cleared by any accepted byte.
    always_comb begin
        to_d        = '0;
        timeout_hit = 1'b0;
        if (busy && !in_valid) begin
            if (to_q == TIMEOUT_CYC - 1) begin
                timeout_hit = 1'b1;
            end else begin
                to_d = to_q + 32'd1;
            end
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    // Never fires; the parameter stays referenced so both builds share one parameter list.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // Frame parser: next state, word assembly, checksum and write strobe.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        hdr_word    = {hi_q, in_data};

        if (in_valid) begin
            case (state_q)
                StIdle, StRun: begin
                    if (in_data == SyncByte) begin
                        state_d = StAddrHi;
                        err_d   = 1'b0;
                        acc_d   = '0;
                    end
                end
                StAddrHi: begin
                    hi_d    = in_data;
                    state_d = StAddrLo;
                end
                StAddrLo: begin
                    addr_d  = hdr_word[ADDR_W-1:0];
                    state_d = StCntHi;
                end
                StCntHi: begin
                    hi_d    = in_data;
                    state_d = StCntLo;
                end
                StCntLo: begin
                    cnt_d   = hdr_word;
                    idx_d   = 2'd0;
                    state_d = (hdr_word == 16'd0) ? StChk : StData;
                end
                StData: begin
                    asm_d = {asm_q[15:0], in_data};
                    acc_d = acc_q ^ in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = {asm_q, in_data};
                        addr_d      = addr_q + ADDR_W'(1);
                        cnt_d       = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = StChk;
                        end
                    end
                end
                StChk: begin
                    if (in_data == acc_q) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (timeout_hit) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hi_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            acc_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            acc_q       <= acc_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
